// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: tagged 64-bit bus memory model serving 8-beat blocks after a fixed latency.
// Block writes into the array are enabled by defining SYSBUS_RESP_WRITE_EN.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 1024,
  parameter int BEATS          = 8,
  parameter int LATENCY        = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0]     bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]      bus_reqtag,
  output logic                          bus_reqack,
  output logic                          bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0]     bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]      bus_resptag,
  input  logic                          bus_respack,
  input  logic                          init_we,
  input  logic [$clog2(MEM_WORDS)-1:0]  init_addr,
  input  logic [BUS_DATA_WIDTH-1:0]     init_data
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int LW = $clog2(LATENCY + 1);
`ifdef SYSBUS_RESP_WRITE_EN
  localparam logic WRITE_EN = 1'b1;
`else
  localparam logic WRITE_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, WAIT, RESP, WDATA, WACK} state_t;
  state_t                    state_q, state_d;
  logic [2:0]                beat_q, beat_d;
  logic [LW-1:0]             lat_q, lat_d;
  logic [AW-1:0]             base_q, base_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                      ack_q, ack_d;
  logic                      mem_we;
  logic [AW-1:0]             mem_addr, rd_addr;
  logic [BUS_DATA_WIDTH-1:0] mem_wdata;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                      last_beat;
  assign rd_addr   = base_q + AW'(beat_q);
  assign last_beat = beat_q == 3'(BEATS - 1);
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    base_d    = base_q;
    tag_d     = tag_q;
    ack_d     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = init_addr;
    mem_wdata = init_data;
    case (state_q)
      IDLE: begin
        // preload owns the array port in IDLE even when a request arrives
        mem_we = init_we;
        if (bus_reqcyc) begin
          ack_d   = 1'b1;
          base_d  = {bus_req[AW+2:6], 3'b000};
          tag_d   = bus_reqtag;
          beat_d  = 3'd0;
          lat_d   = LW'(LATENCY - 1);
          state_d = bus_reqtag[BUS_TAG_WIDTH-1] ? WDATA : WAIT;
        end
      end
      WAIT: begin
        state_d = lat_q == '0 ? RESP : WAIT;
        lat_d   = lat_q == '0 ? lat_q : lat_q - 1'b1;
      end
      RESP: if (bus_respack) begin
        beat_d  = beat_q + 3'd1;
        state_d = last_beat ? IDLE : RESP;
      end
      WDATA: if (bus_reqcyc) begin
        ack_d     = 1'b1;
        mem_we    = WRITE_EN;
        mem_addr  = rd_addr;
        mem_wdata = bus_req;
        beat_d    = beat_q + 3'd1;
        state_d   = last_beat ? WACK : WDATA;
      end
      WACK: state_d = bus_respack ? IDLE : WACK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lat_q   <= '0;
      base_q  <= '0;
      tag_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
      base_q  <= base_d;
      tag_q   <= tag_d;
      ack_q   <= ack_d;
    end
  end
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign bus_reqack  = ack_q;
  assign bus_respcyc = state_q == RESP || state_q == WACK;
  assign bus_resp    = state_q == RESP ? mem[rd_addr] : '0;
  assign bus_resptag = bus_respcyc ? tag_q : '0;
endmodule

// File: tb/tb_sysbus_mem_responder.sv
// tb_sysbus_mem_responder: queue-based reference model with per-cycle compare plus directed literal checks.
module tb_sysbus_mem_responder;
  localparam int L = 4;
  localparam int W = 1024;
  logic        clk = 0, reset = 1;
  logic        bus_reqcyc = 0, bus_respack = 1, init_we = 0;
  logic [63:0] bus_req = 0, init_data = 0;
  logic [12:0] bus_reqtag = 0;
  logic [9:0]  init_addr = 0;
  logic        bus_reqack, bus_respcyc;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  sysbus_mem_responder dut (
    .clk(clk), .reset(reset), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .bus_respack(bus_respack), .init_we(init_we), .init_addr(init_addr), .init_data(init_data)
  );
  always #5 clk = ~clk;
  typedef struct {logic [63:0] d; logic [12:0] t;} beat_t;
  beat_t       q[$];
  logic [63:0] mem_m [W];
  logic [12:0] wtag;
  logic        exp_ack = 0, ack_mode = 0, idle, resp_v, exp_rc;
  int          cyc = 0, ready = 0, wleft = 0, wbase = 0, idx = 0, base = 0, dut_hs = 0;
  int          errors = 0, checks = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // reference model: a memory array plus a queue of the beats still owed to the initiator
  initial forever begin
    @(posedge clk);
    if (reset) begin
      q.delete();
      wleft   = 0;
      exp_ack = 0;
      cyc++;
    end else begin
      resp_v  = q.size() > 0 && cyc >= ready;
      idle    = q.size() == 0 && wleft == 0;
      exp_ack = 0;
      if (resp_v && bus_respack) void'(q.pop_front());
      cyc++;
      if (idle) begin
        if (init_we) mem_m[init_addr] = init_data;
        if (bus_reqcyc) begin
          exp_ack = 1;
          idx  = int'((bus_req / 8) % W);
          base = idx - idx % 8;
          if (bus_reqtag[12]) begin
            wleft = 8;
            wbase = base;
            wtag  = bus_reqtag;
          end else begin
            for (int k = 0; k < 8; k++) q.push_back('{mem_m[(base + k) % W], bus_reqtag});
            ready = cyc + L;
          end
        end
      end else if (wleft > 0 && bus_reqcyc) begin
        exp_ack = 1;
`ifdef SYSBUS_RESP_WRITE_EN
        mem_m[(wbase + 8 - wleft) % W] = bus_req;
`endif
        wleft--;
        if (wleft == 0) begin
          q.push_back('{64'd0, wtag});
          ready = cyc;
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    exp_rc = !reset && q.size() > 0 && cyc >= ready;
    chk("reqack", {63'd0, bus_reqack}, {63'd0, !reset && exp_ack});
    chk("respcyc", {63'd0, bus_respcyc}, {63'd0, exp_rc});
    chk("resp", bus_resp, exp_rc ? q[0].d : 64'd0);
    chk("resptag", {51'd0, bus_resptag}, {51'd0, exp_rc ? q[0].t : 13'd0});
    if (!reset && bus_respcyc && bus_respack) dut_hs++;
  end
  initial forever begin
    @(posedge clk);
    #1 bus_respack = ack_mode ? ~bus_respack : 1'b1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_req(input logic [63:0] a, input logic [12:0] t);
    int n = 0;
    bus_reqcyc = 1; bus_req = a; bus_reqtag = t;
    do begin tick(); n++; end while (!bus_reqack && n < 100);
    bus_reqcyc = 0;
    checks++;
    if (!bus_reqack) begin errors++; $display("FAIL req_timeout: got no ack required ack for %h", a); end
  endtask
  task automatic wait_idle;
    int n = 0;
    while ((q.size() != 0 || wleft != 0) && n < 200) begin tick(); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL idle_timeout: got busy required idle"); end
  endtask
  int h0, e1, e2;
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reqack", {63'd0, bus_reqack}, 64'd0);
    chk("rst_respcyc", {63'd0, bus_respcyc}, 64'd0);
    chk("rst_resp", bus_resp, 64'd0);
    chk("rst_resptag", {51'd0, bus_resptag}, 64'd0);
    reset = 0;
    for (int i = 8; i < 24; i++) begin
      init_we = 1; init_addr = 10'(i); init_data = (i < 16) ? 64'h1000 + 64'(i) : 64'h2000 + 64'(i);
      tick();
    end
    init_we = 0;
    // basic read, respack held high
    send_req(64'h40, 13'h055);
    chk("t1_ack", {63'd0, bus_reqack}, 64'd1);
    repeat (L) @(negedge clk);
    chk("t1_wait", {63'd0, bus_respcyc}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_beat", bus_resp, 64'h1008 + 64'(k));
    end
    chk("t1_tag", {51'd0, bus_resptag}, 64'h055);
    @(negedge clk);
    chk("t1_end", {63'd0, bus_respcyc}, 64'd0);
    // respack toggling
    ack_mode = 1;
    h0 = dut_hs;
    send_req(64'h40, 13'h066);
    wait_idle();
    ack_mode = 0;
    chk("t2_hs", 64'(dut_hs - h0), 64'd8);
    // block write, then read back
    send_req(64'h80, 13'h1ABC);
    for (int b = 0; b < 8; b++) begin
      bus_reqcyc = 1; bus_req = 64'hA0 + 64'(b);
      tick();
    end
    bus_reqcyc = 0;
    chk("t3_wack", {63'd0, bus_respcyc}, 64'd1);
    chk("t3_wtag", {51'd0, bus_resptag}, 64'h1ABC);
    chk("t3_wdata", bus_resp, 64'd0);
    wait_idle();
    send_req(64'h80, 13'h077);
    repeat (L + 1) @(negedge clk);
`ifdef SYSBUS_RESP_WRITE_EN
    chk("t3_rd0", bus_resp, 64'hA0);
`else
    chk("t3_rd0", bus_resp, 64'h2010);
`endif
    wait_idle();
    // address alias
    send_req(64'h40 + 64'(W * 8), 13'h088);
    repeat (L + 1) @(negedge clk);
    chk("t4_alias", bus_resp, 64'h1008);
    wait_idle();
    // reset at the third read beat
    send_req(64'h48, 13'h099);
    repeat (L + 2) @(negedge clk);
    @(posedge clk);
    #1 reset = 1;
    #1;
    chk("t5_rc", {63'd0, bus_respcyc}, 64'd0);
    chk("t5_resp", bus_resp, 64'd0);
    chk("t5_tag", {51'd0, bus_resptag}, 64'd0);
    repeat (2) tick();
    reset = 0;
    send_req(64'h40, 13'h0AA);
    wait_idle();
    // request held during RESP
    send_req(64'h40, 13'h0BB);
    e1 = cyc;
    send_req(64'h40, 13'h0CC);
    e2 = cyc;
    chk("t6_gap", 64'(e2 - e1), 64'(L + 9));
    wait_idle();
    // preload and request in the same cycle
    bus_reqcyc = 1; bus_req = 64'h40; bus_reqtag = 13'h0DD;
    init_we = 1; init_addr = 10'd8; init_data = 64'h5555;
    tick();
    init_we = 0;
    chk("t7_ack", {63'd0, bus_reqack}, 64'd1);
    bus_reqcyc = 0;
    repeat (L + 1) @(negedge clk);
    chk("t7_beat0", bus_resp, 64'h5555);
    wait_idle();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sysbus_mem_responder.md
# sysbus_mem_responder

Memory-side responder for the 64-bit tagged system bus that the core's fetch and memory path drives as initiator. It accepts one block request at a time and serves eight 64-bit beats, one 64-byte cache block per request, from an internal word array after a fixed latency. Block writes land in the same array. It stands in for main memory in core-level simulation and bring-up.

## Interface
- BUS_DATA_WIDTH, 64: beat width.
- BUS_TAG_WIDTH, 13: tag width. Bit 12 = 1 is a write; bits 11:0 are opaque and echoed back.
- MEM_WORDS, 1024: array depth in 64-bit words; power of two.
- BEATS, 8: beats per block.
- LATENCY, 4: idle cycles between the request ack and the first read beat; minimum 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- bus_reqcyc  in  1  request/write-data valid.
- bus_req  in  64  byte address, or write-data beat.
- bus_reqtag  in  13  request tag.
- bus_reqack  out  1  request or data-beat accepted.
- bus_respcyc  out  1  response beat valid.
- bus_resp  out  64  response data.
- bus_resptag  out  13  tag of the request being answered.
- bus_respack  in  1  initiator consumed the current beat.
- init_we  in  1  backdoor preload write, used only when the block is IDLE.
- init_addr  in  log2(MEM_WORDS)  preload word index.
- init_data  in  64  preload data.

## Operation
- The array is not reset.
- Word index = bus_req[3+log2(MEM_WORDS)-1:3]. Block base = that index with its low 3 bits cleared. Beat k reads or writes word (base+k) mod MEM_WORDS.
- States:
  - IDLE: bus_reqcyc=1 latches address and tag and selects a path: read → WAIT, write → WDATA.
  - WAIT: counts LATENCY cycles, then → RESP.
  - RESP: drives beat k. A handshake is bus_respcyc & bus_respack; each one increments k. The handshake on the last beat → IDLE.
  - WDATA: each cycle with bus_reqcyc=1 writes bus_req to word base+k and increments k. After BEATS beats → WACK.
  - WACK: one response beat with bus_resp=0 and bus_resptag=the write tag. On handshake → IDLE.
- Ack and request rules:
  - bus_reqack is registered. It pulses one cycle after each accepted request or data beat.
  - bus_reqcyc seen in WAIT, RESP or WACK is ignored and not acked. The initiator holds the request until it sees the ack.
- Response beat rules:
  - bus_resp and bus_resptag hold steady while bus_respcyc=1 and bus_respack=0.
  - init_we outside IDLE is ignored.

## Timing
- Reset value of every output is 0, and the FSM returns to IDLE. This holds when reset hits mid-transfer: the partial transfer is abandoned, array words already written are kept, and no response is issued.
- Read, request sampled at cycle t:
  - bus_reqack=1 at t+1.
  - bus_respcyc=1 from t+1+LATENCY.
  - With bus_respack held high, one beat per cycle. The last beat is at t+LATENCY+BEATS, and bus_respcyc=0 the cycle after.
- Back-to-back requests:
  - The next request is sampled no earlier than the cycle after the final handshake.
  - An IDLE request and a preload in the same cycle: the preload wins the array port; the request is still accepted.
- Write:
  - The header is acked at t+1. Data beats are accepted from t+1 onward, with their acks one cycle after each beat.
  - WACK bus_respcyc rises one cycle after the last data beat.
- Counters: the beat counter is 3 bits and wraps only at block end. The latency counter reloads on every request.

## Configuration
- SYSBUS_RESP_WRITE_EN.
- Defined: write path as above.
- Undefined:
  - A write-tagged request is still acked, its BEATS data beats are consumed and acked, and WACK is still issued.
  - The array is not modified. Preload still works.

## Test plan
- Read at 0x40, word 8..15 preloaded with 0x1000+i, respack held 1: reqack at t+1; beats 0x1008..0x100F at t+5..t+12; resptag equals reqtag.
- Same read with respack toggling 1,0: each beat held over the stall; 8 handshakes total; no beat skipped or repeated.
- Write to 0x80 with beats 0xA0..0xA7, then read 0x80 (WRITE_EN on): WACK tag matches the write tag; read returns 0xA0..0xA7. With WRITE_EN off: read returns the preloaded values.
- Address 0x40 + MEM_WORDS*8: aliases to the same block as 0x40.
- Assert reset at the 3rd read beat: all outputs 0 that cycle; the next read of the same block completes normally.
- bus_reqcyc held high during RESP: no extra reqack; the second request is acked only after the return to IDLE.
